ram_protocol_monitor: RTL and testbench
=======================================

Name: ram_protocol_monitor

Overview:
Synthesizable, parametrised protocol monitor for the SPI-slave single-port RAM command interface. It taps rx_valid/din/tx_valid/dout and tracks the write-address/write-data/read-address/read-data sequence with a state machine. It times read responses and reports violations as coded error pulses plus saturating statistics counters. It sits beside the RAM in the wrapper and is usable both in simulation and on silicon for debug.

Parameters:
DATA_W, 8, RAM data/address width; din is DATA_W+2 bits, din[DATA_W+1:DATA_W] is the command.
MAX_READ_LAT, 2, max cycles from an accepted read-data command to tx_valid (>=1).
CNT_W, 16, width of the statistics counters.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rx_valid  input  1  command/data valid into RAM
din  input  DATA_W+2  command[DATA_W+1:DATA_W] + payload
tx_valid  input  1  RAM read-data valid
dout  input  DATA_W  RAM read data
err_valid  output  1  one-cycle pulse, error detected
err_code  output  4  error code, valid with err_valid
err_sticky  output  1  set on any error, cleared only by rst
wr_count  output  CNT_W  completed write-data commands
rd_count  output  CNT_W  completed reads (tx_valid in RD_WAIT)
err_count  output  CNT_W  cycles with err_valid
busy  output  1  state != IDLE

Behaviour:
- Reset, rst high at a clock edge: all outputs 0, state IDLE, read timer 0, all prior-cycle flags cleared.
- Commands are sampled only when rx_valid=1: 00 WADDR, 01 WDATA, 10 RADDR, 11 RDATA.
- FSM states: IDLE, WR_ARMED, RD_ARMED, RD_WAIT.
  - Any state except RD_WAIT: 00 -> WR_ARMED; 10 -> RD_ARMED. Overwriting an armed address is legal.
  - WR_ARMED + 01 -> IDLE, wr_count++.
  - 01 in IDLE/RD_ARMED -> code 1 NO_WADDR; state unchanged.
  - RD_ARMED + 11 -> RD_WAIT, timer=0.
  - 11 in IDLE/WR_ARMED -> code 2 NO_RADDR; state unchanged.
  - RD_WAIT: timer increments each cycle. tx_valid -> IDLE, rd_count++. If the timer reaches MAX_READ_LAT without tx_valid -> code 3 RD_TIMEOUT, then IDLE.
  - RD_WAIT + rx_valid without tx_valid in the same cycle -> code 6 OVERLAP; the command is dropped and the state stays RD_WAIT.
  - RD_WAIT + rx_valid with tx_valid in the same cycle: the read completes, then the command is processed as if from IDLE, same cycle.
- Timing: 11 accepted at cycle T; tx_valid is legal in T+1..T+MAX_READ_LAT.
- tx_valid outside RD_WAIT -> code 4 SPUR_TX.
- tx_valid high two consecutive cycles -> code 5 TX_LONG on the second cycle; SPUR_TX is suppressed for that cycle.
- Reset check: in the first cycle with rst low after a cycle with rst high, tx_valid=1 or dout!=0 -> code 8 RST_OUT.
- Latency: err_valid/err_code are registered, one cycle after the offending sampled cycle. Counters update on the same edge.
- Simultaneous errors: one report per cycle. Priority is 8 > 7 > 5 > 4 > 3 > 6 > 2 > 1.
- err_count increments once per error cycle.
- All counters saturate at all-ones (no wrap).
- err_code holds 0 whenever err_valid=0.
- rst mid-operation, e.g. in RD_WAIT: abandons the transaction, no timeout reported.

Optional Feature:
MON_DOUT_CHECK_EN.
- Defined: a shadow memory of 2^DATA_W entries x DATA_W bits, each with a valid bit.
  - WADDR latches the write address; WDATA in WR_ARMED writes the shadow entry and sets its valid bit.
  - RADDR latches the read address.
  - On a completing tx_valid whose shadow entry is valid and dout != shadow -> code 7 DATA_MISMATCH. Unwritten addresses are not checked.
  - rst clears all valid bits.
- Undefined: no shadow storage; code 7 is never produced.

Test Plan:
1. rst 2 cycles, then 00_12h, 01_ABh -> wr_count=1, err_valid never set, busy 1 for one cycle.
2. After reset, 01_55h -> next cycle err_valid=1, err_code=1, err_count=1, err_sticky=1; wr_count=0.
3. 00_12h, 01_ABh, 10_12h, 11_00h, tx_valid at T+1 with dout=ABh -> rd_count=1, no error. Repeat with dout=ACh (MON_DOUT_CHECK_EN defined) -> err_code=7.
4. 10_05h, 11_00h, no tx_valid (MAX_READ_LAT=2) -> err_code=3 at T+3, state IDLE. Also tx_valid at T+1 together with rx_valid 00_07h -> rd_count=1, state WR_ARMED, no OVERLAP.
5. tx_valid in IDLE -> code 4. Complete a legal read, then hold tx_valid 2 cycles -> code 5 only. Deassert rst with dout=01h -> code 8.
6. rst asserted in RD_WAIT for 1 cycle -> all counters 0, busy 0, err_sticky 0, no code 3 afterwards. Force 2^CNT_W WDATA completions -> wr_count holds all-ones.

Source files
------------

// File: rtl/ram_protocol_monitor.sv
// ram_protocol_monitor
//   Protocol monitor for the SPI-slave single-port RAM command interface.
//   It watches rx_valid/din/tx_valid/dout and follows the sequence
//   write-address -> write-data and read-address -> read-data -> response.
//   It reports violations as registered, coded one-cycle error pulses and
//   keeps saturating statistics counters.
//
//   Optional feature macro: MON_DOUT_CHECK_EN
//     When defined, a shadow copy of the RAM (with per-entry valid bits)
//     checks returned read data and reports code 7 on a mismatch.
//
//   Error codes (priority 8 > 7 > 5 > 4 > 3 > 6 > 2 > 1):
//     1 NO_WADDR  2 NO_RADDR  3 RD_TIMEOUT  4 SPUR_TX
//     5 TX_LONG   6 OVERLAP   7 DATA_MISMATCH  8 RST_OUT
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   rx_valid   in   command/data valid into the RAM
//   din        in   {command[1:0], payload[DATA_W-1:0]}
//   tx_valid   in   RAM read-data valid
//   dout       in   RAM read data
//   err_valid  out  one-cycle error pulse
//   err_code   out  error code, 0 whenever err_valid is 0
//   err_sticky out  set on any error, cleared only by rst
//   wr_count   out  completed write-data commands (saturating)
//   rd_count   out  completed reads (saturating)
//   err_count  out  cycles with an error (saturating)
//   busy       out  monitor state is not IDLE
module ram_protocol_monitor #(
  parameter int DATA_W       = 8,
  parameter int MAX_READ_LAT = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] dout,
  output logic              err_valid,
  output logic [3:0]        err_code,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int TMR_W = $clog2(MAX_READ_LAT + 1);
  // Timer value seen in the last legal response cycle (T+MAX_READ_LAT).
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_READ_LAT - 1);

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;

  localparam logic [3:0] ERR_NONE       = 4'd0;
  localparam logic [3:0] ERR_NO_WADDR   = 4'd1;
  localparam logic [3:0] ERR_NO_RADDR   = 4'd2;
  localparam logic [3:0] ERR_RD_TIMEOUT = 4'd3;
  localparam logic [3:0] ERR_SPUR_TX    = 4'd4;
  localparam logic [3:0] ERR_TX_LONG    = 4'd5;
  localparam logic [3:0] ERR_OVERLAP    = 4'd6;
  localparam logic [3:0] ERR_MISMATCH   = 4'd7;
  localparam logic [3:0] ERR_RST_OUT    = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ARMED = 2'd1,
    ST_RD_ARMED = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

  // Flags are ordered {rst_out, mismatch, tx_long, spur_tx, timeout,
  // overlap, no_raddr, no_waddr}, i.e. highest priority in the MSB.
  function automatic logic [3:0] pick_code(input logic [7:0] flags);
    logic [3:0] code;
    code = ERR_NONE;
    if (flags[7])      code = ERR_RST_OUT;
    else if (flags[6]) code = ERR_MISMATCH;
    else if (flags[5]) code = ERR_TX_LONG;
    else if (flags[4]) code = ERR_SPUR_TX;
    else if (flags[3]) code = ERR_RD_TIMEOUT;
    else if (flags[2]) code = ERR_OVERLAP;
    else if (flags[1]) code = ERR_NO_RADDR;
    else if (flags[0]) code = ERR_NO_WADDR;
    else               code = ERR_NONE;
    return code;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_r;
  state_t            hold_state_s;   // next state if no command is processed
  state_t            base_state_s;   // state the command is decoded against
  state_t            cmd_state_s;    // next state produced by the command
  state_t            state_nxt_s;
  logic [TMR_W-1:0]  timer_r;
  logic [TMR_W-1:0]  timer_nxt_s;
  logic              prev_tx_r;
  logic              rst_seen_r;
  logic              err_valid_r;
  logic [3:0]        err_code_r;
  logic              err_sticky_r;
  logic [CNT_W-1:0]  wr_count_r;
  logic [CNT_W-1:0]  rd_count_r;
  logic [CNT_W-1:0]  err_count_r;
  logic              busy_r;

  logic [1:0]        cmd_s;
  logic              cmd_en_s;
  logic              cmd_wr_s;
  logic              cmd_no_waddr_s;
  logic              cmd_no_raddr_s;
  logic              wr_inc_s;
  logic              rd_inc_s;
  logic              data_bad_s;
  logic              e_timeout_s;
  logic              e_overlap_s;
  logic              e_mismatch_s;
  logic              e_spur_tx_s;
  logic              e_tx_long_s;
  logic              e_rst_out_s;
  logic [7:0]        flags_s;
  logic [3:0]        code_s;
  logic              any_err_s;

  assign cmd_s = din[DATA_W+1:DATA_W];

`ifdef MON_DOUT_CHECK_EN
  logic [DATA_W-1:0]        wr_addr_r;
  logic [DATA_W-1:0]        rd_addr_r;
  logic [DATA_W-1:0]        shadow_mem_r [0:(1<<DATA_W)-1];
  logic [(1<<DATA_W)-1:0]   shadow_vld_r;

  // Address latches and shadow valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_r    <= '0;
      rd_addr_r    <= '0;
      shadow_vld_r <= '0;
    end else begin
      if (cmd_en_s && (cmd_s == CMD_WADDR)) wr_addr_r <= din[DATA_W-1:0];
      if (cmd_en_s && (cmd_s == CMD_RADDR)) rd_addr_r <= din[DATA_W-1:0];
      if (wr_inc_s) shadow_vld_r[wr_addr_r] <= 1'b1;
    end
  end

  // Shadow data storage, meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && wr_inc_s) shadow_mem_r[wr_addr_r] <= din[DATA_W-1:0];
  end

  // The completing read is checked against the address latched before it.
  assign data_bad_s = shadow_vld_r[rd_addr_r] && (dout != shadow_mem_r[rd_addr_r]);
`else
  logic payload_unused_s;
  assign payload_unused_s = ^din[DATA_W-1:0];
  assign data_bad_s       = 1'b0;
`endif

  // Read-wait handling: response, timeout and overlap before command decode.
  always_comb begin
    hold_state_s = state_r;
    base_state_s = state_r;
    timer_nxt_s  = '0;
    cmd_en_s     = 1'b0;
    rd_inc_s     = 1'b0;
    e_timeout_s  = 1'b0;
    e_overlap_s  = 1'b0;
    e_mismatch_s = 1'b0;
    if (state_r == ST_RD_WAIT) begin
      if (tx_valid) begin
        // Read completes; a same-cycle command is then decoded as from IDLE.
        rd_inc_s     = 1'b1;
        e_mismatch_s = data_bad_s;
        hold_state_s = ST_IDLE;
        base_state_s = ST_IDLE;
        cmd_en_s     = rx_valid;
      end else if (timer_r == TMR_LAST) begin
        e_timeout_s  = 1'b1;
        e_overlap_s  = rx_valid;
        hold_state_s = ST_IDLE;
      end else begin
        timer_nxt_s  = timer_r + TMR_W'(1);
        e_overlap_s  = rx_valid;
      end
    end else begin
      cmd_en_s = rx_valid;
    end
  end

  // Command decode against the effective current state.
  always_comb begin
    cmd_state_s    = base_state_s;
    cmd_wr_s       = 1'b0;
    cmd_no_waddr_s = 1'b0;
    cmd_no_raddr_s = 1'b0;
    case (cmd_s)
      CMD_WADDR: cmd_state_s = ST_WR_ARMED;
      CMD_WDATA: begin
        if (base_state_s == ST_WR_ARMED) begin
          cmd_state_s = ST_IDLE;
          cmd_wr_s    = 1'b1;
        end else begin
          cmd_no_waddr_s = 1'b1;
        end
      end
      CMD_RADDR: cmd_state_s = ST_RD_ARMED;
      CMD_RDATA: begin
        if (base_state_s == ST_RD_ARMED) begin
          cmd_state_s = ST_RD_WAIT;
        end else begin
          cmd_no_raddr_s = 1'b1;
        end
      end
      default: cmd_state_s = base_state_s;
    endcase
  end

  // Timer leaves the read-wait handling as 0 whenever RD_WAIT is entered.
  assign state_nxt_s = cmd_en_s ? cmd_state_s : hold_state_s;
  assign wr_inc_s    = cmd_en_s & cmd_wr_s;

  // tx_valid checks; a second consecutive tx_valid is TX_LONG, not SPUR_TX.
  assign e_tx_long_s = tx_valid & prev_tx_r;
  assign e_spur_tx_s = tx_valid & (state_r != ST_RD_WAIT) & ~prev_tx_r;
  assign e_rst_out_s = rst_seen_r & (tx_valid | (dout != '0));

  assign flags_s   = {e_rst_out_s, e_mismatch_s, e_tx_long_s, e_spur_tx_s,
                      e_timeout_s, e_overlap_s,
                      cmd_en_s & cmd_no_raddr_s, cmd_en_s & cmd_no_waddr_s};
  assign code_s    = pick_code(flags_s);
  assign any_err_s = |flags_s;

  // State, timer, history flags, error report and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      prev_tx_r    <= 1'b0;
      rst_seen_r   <= 1'b1;
      err_valid_r  <= 1'b0;
      err_code_r   <= ERR_NONE;
      err_sticky_r <= 1'b0;
      wr_count_r   <= '0;
      rd_count_r   <= '0;
      err_count_r  <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      prev_tx_r   <= tx_valid;
      rst_seen_r  <= 1'b0;
      err_valid_r <= any_err_s;
      err_code_r  <= code_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (any_err_s) begin
        err_sticky_r <= 1'b1;
        err_count_r  <= sat_inc(err_count_r);
      end
      if (wr_inc_s) wr_count_r <= sat_inc(wr_count_r);
      if (rd_inc_s) rd_count_r <= sat_inc(rd_count_r);
    end
  end

  assign err_valid  = err_valid_r;
  assign err_code   = err_code_r;
  assign err_sticky = err_sticky_r;
  assign wr_count   = wr_count_r;
  assign rd_count   = rd_count_r;
  assign err_count  = err_count_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ram_protocol_monitor.sv
// Directed testbench for ram_protocol_monitor with an expected-code queue.
module tb_ram_protocol_monitor;

  localparam int DATA_W = 8;
  localparam int LAT    = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic              tx_valid;
  logic [DATA_W-1:0] dout;
  logic              err_valid;
  logic [3:0]        err_code;
  logic              err_sticky;
  logic [CNT_W-1:0]  wr_count;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  int         total;
  int         bad;
  logic [3:0] exp_q[$];
  int         exp_wr;
  int         exp_rd;
  int         exp_err;
  logic       exp_sticky;
  logic [3:0] mis_code;

  ram_protocol_monitor #(
    .DATA_W(DATA_W), .MAX_READ_LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
    .tx_valid(tx_valid), .dout(dout), .err_valid(err_valid),
    .err_code(err_code), .err_sticky(err_sticky), .wr_count(wr_count),
    .rd_count(rd_count), .err_count(err_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".wr"},     32'(wr_count),   32'(exp_wr));
    chk({tag, ".rd"},     32'(rd_count),   32'(exp_rd));
    chk({tag, ".errcnt"}, 32'(err_count),  32'(exp_err));
    chk({tag, ".sticky"}, 32'(err_sticky), 32'(exp_sticky));
  endtask

  // One sampled cycle: drive at negedge, push expectation, check next negedge.
  task automatic step(input string tag, input logic rv, input logic [1:0] c,
                      input logic [7:0] p, input logic tv, input logic [7:0] dv,
                      input logic [3:0] ec, input logic wi, input logic ri);
    logic [3:0] want;
    rx_valid = rv;
    din      = {c, p};
    tx_valid = tv;
    dout     = dv;
    exp_q.push_back(ec);
    if (wi) exp_wr = sat(exp_wr);
    if (ri) exp_rd = sat(exp_rd);
    if (ec != 4'd0) begin
      exp_err    = sat(exp_err);
      exp_sticky = 1'b1;
    end
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      want = exp_q.pop_front();
      chk({tag, ".valid"}, 32'(err_valid), 32'(want != 4'd0));
      chk({tag, ".code"},  32'(err_code),  32'(want));
    end
    chk_counts(tag);
    rx_valid = 1'b0;
    din      = '0;
    tx_valid = 1'b0;
    dout     = '0;
  endtask

  task automatic do_reset(input string tag, input int n);
    rst      = 1'b1;
    rx_valid = 1'b0;
    din      = '0;
    tx_valid = 1'b0;
    dout     = '0;
    repeat (n) @(negedge clk);
    rst        = 1'b0;
    exp_wr     = 0;
    exp_rd     = 0;
    exp_err    = 0;
    exp_sticky = 1'b0;
    chk({tag, ".rst_valid"}, 32'(err_valid), 32'd0);
    chk({tag, ".rst_code"},  32'(err_code),  32'd0);
    chk({tag, ".rst_busy"},  32'(busy),      32'd0);
    chk_counts({tag, ".rst"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef MON_DOUT_CHECK_EN
    mis_code = 4'd7;
`else
    mis_code = 4'd0;
`endif

    // 1: legal write, busy for exactly one cycle
    do_reset("t1", 2);
    step("t1.waddr", 1'b1, 2'b00, 8'h12, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    chk("t1.busy_armed", 32'(busy), 32'd1);
    step("t1.wdata", 1'b1, 2'b01, 8'hAB, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    chk("t1.busy_done", 32'(busy), 32'd0);
    step("t1.idle", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    // 2: write data without address
    do_reset("t2", 1);
    step("t2.nowaddr", 1'b1, 2'b01, 8'h55, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0);
    step("t2.idle", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    // 3: write then read back, good and bad data
    do_reset("t3", 1);
    step("t3.waddr", 1'b1, 2'b00, 8'h12, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t3.wdata", 1'b1, 2'b01, 8'hAB, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    step("t3.raddr", 1'b1, 2'b10, 8'h12, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t3.rdata", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    chk("t3.busy_wait", 32'(busy), 32'd1);
    step("t3.resp_ok", 1'b0, 2'b00, 8'h00, 1'b1, 8'hAB, 4'd0, 1'b0, 1'b1);
    step("t3.raddr2", 1'b1, 2'b10, 8'h12, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t3.rdata2", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t3.resp_bad", 1'b0, 2'b00, 8'h00, 1'b1, 8'hAC, mis_code, 1'b0, 1'b1);
    step("t3.idle", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    // 4: timeout, completion with same-cycle command, overlap, no raddr
    do_reset("t4", 1);
    step("t4.raddr", 1'b1, 2'b10, 8'h05, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t4.rdata", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t4.wait1", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    chk("t4.busy_wait1", 32'(busy), 32'd1);
    step("t4.timeout", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd3, 1'b0, 1'b0);
    chk("t4.busy_idle", 32'(busy), 32'd0);
    step("t4.raddr2", 1'b1, 2'b10, 8'h05, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t4.rdata2", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t4.resp_cmd", 1'b1, 2'b00, 8'h07, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1);
    chk("t4.busy_warmed", 32'(busy), 32'd1);
    step("t4.wdata", 1'b1, 2'b01, 8'h33, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    step("t4.raddr3", 1'b1, 2'b10, 8'h05, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t4.rdata3", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t4.overlap", 1'b1, 2'b00, 8'h09, 1'b0, 8'h00, 4'd6, 1'b0, 1'b0);
    step("t4.resp_late", 1'b0, 2'b00, 8'h00, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1);
    step("t4.noraddr", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd2, 1'b0, 1'b0);
    step("t4.idle", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    // 5: spurious tx, long tx, reset output checks
    do_reset("t5", 1);
    step("t5.idle0", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t5.spur", 1'b0, 2'b00, 8'h00, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0);
    step("t5.idle1", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t5.raddr", 1'b1, 2'b10, 8'h01, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t5.rdata", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t5.resp", 1'b0, 2'b00, 8'h00, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1);
    step("t5.txlong", 1'b0, 2'b00, 8'h00, 1'b1, 8'h00, 4'd5, 1'b0, 1'b0);
    step("t5.idle2", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    do_reset("t5b", 1);
    step("t5.rstout_dout", 1'b0, 2'b00, 8'h00, 1'b0, 8'h01, 4'd8, 1'b0, 1'b0);
    step("t5.idle3", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    do_reset("t5c", 1);
    step("t5.rstout_tx", 1'b0, 2'b00, 8'h00, 1'b1, 8'h00, 4'd8, 1'b0, 1'b0);
    step("t5.idle4", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    // 6: reset while waiting for read data, then counter saturation
    do_reset("t6", 1);
    step("t6.nowaddr", 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0);
    step("t6.raddr", 1'b1, 2'b10, 8'h03, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step("t6.rdata", 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    do_reset("t6b", 1);
    for (int i = 0; i < 3; i++) begin
      step("t6.after_rst", 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    end
    chk("t6.busy", 32'(busy), 32'd0);
    for (int i = 0; i < CMAX + 5; i++) begin
      step("t6.sat_waddr", 1'b1, 2'b00, 8'(i), 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
      step("t6.sat_wdata", 1'b1, 2'b01, 8'(i), 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    end
    chk("t6.wr_sat", 32'(wr_count), 32'(CMAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
